// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock timekeeping controller.
package clock_pkg;

    // Controller mode; encoding 2'd3 is unused and recovers to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } mode_t;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

    // Next BCD value of a two-digit counter that wraps from max back to 00.
    function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic [7:0] max);
        logic [7:0] result;
        if (value == max) begin
            result = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MAX; carry flags the wrapping increment.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = MIN_MAX_BCD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    logic [7:0] r_value;

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 8'h00;
        end else if (clr) begin
            r_value <= 8'h00;
        end else if (inc) begin
            r_value <= bcd_next(r_value, MAX);
        end else begin
            r_value <= r_value;
        end
    end

    assign tens  = r_value[7:4];
    assign units = r_value[3:0];
    assign carry = inc & (r_value == MAX);

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-setting controller (HH:MM:SS in BCD, 24 h).
// Optional feature macro: HOURLY_CHIME_EN (one-cycle chime on each RUN-mode
// minute 59->00 rollover); without it chime is held at 0.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = HOUR_MAX_BCD,
    parameter logic [7:0] MIN_MAX  = MIN_MAX_BCD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       blink_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_fmt,
    output logic [3:0] bcd_ht,
    output logic [3:0] bcd_hu,
    output logic [3:0] bcd_mt,
    output logic [3:0] bcd_mu,
    output logic [3:0] bcd_st,
    output logic [3:0] bcd_su,
    output logic       day_night,
    output logic [1:0] mode,
    output logic       blank_h,
    output logic       blank_m,
    output logic       chime
);

`ifdef HOURLY_CHIME_EN
    localparam logic CHIME_EN = 1'b1;
`else
    localparam logic CHIME_EN = 1'b0;
`endif

    mode_t r_mode;
    mode_t w_mode_next;
    logic  r_phase;
    logic  w_phase_next;
    logic  r_day_night;
    logic  r_blank_h;
    logic  r_blank_m;
    logic  r_chime;

    logic  w_run;
    logic  w_set_h;
    logic  w_set_m;
    logic  w_sec_inc;
    logic  w_sec_clr;
    logic  w_min_inc;
    logic  w_hour_inc;
    logic  w_sec_carry;
    logic  w_min_carry;
    logic  w_hour_carry;
    logic  w_chime_evt;

    assign w_run   = (r_mode == ST_RUN);
    assign w_set_h = (r_mode == ST_SET_H);
    assign w_set_m = (r_mode == ST_SET_M);

    // Time only advances in RUN; a mode press in a set state swallows btn_inc.
    assign w_sec_inc  = w_run & sec_tick;
    assign w_sec_clr  = w_set_m & btn_mode;
    assign w_min_inc  = (w_run & w_sec_carry) | (w_set_m & btn_inc & ~btn_mode);
    assign w_hour_inc = (w_run & w_min_carry) | (w_set_h & btn_inc & ~btn_mode);

    // Hour rollover always coincides with a minute rollover; both listed for clarity.
    assign w_chime_evt = w_run & (w_min_carry | w_hour_carry);

    bcd_mod_counter #(.MAX(MIN_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_sec_inc),
        .clr   (w_sec_clr),
        .tens  (bcd_st),
        .units (bcd_su),
        .carry (w_sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_min_inc),
        .clr   (1'b0),
        .tens  (bcd_mt),
        .units (bcd_mu),
        .carry (w_min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hour_inc),
        .clr   (1'b0),
        .tens  (bcd_ht),
        .units (bcd_hu),
        .carry (w_hour_carry)
    );

    // Mode sequencing RUN -> SET_H -> SET_M -> RUN; unused encoding returns to RUN.
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            ST_RUN:   if (btn_mode) w_mode_next = ST_SET_H; else w_mode_next = ST_RUN;
            ST_SET_H: if (btn_mode) w_mode_next = ST_SET_M; else w_mode_next = ST_SET_H;
            ST_SET_M: if (btn_mode) w_mode_next = ST_RUN;   else w_mode_next = ST_SET_M;
            default:  w_mode_next = ST_RUN;
        endcase
    end

    // Blink phase: cleared on any mode change, in RUN and after an edit.
    always_comb begin
        w_phase_next = r_phase;
        if ((w_mode_next != r_mode) || (w_mode_next == ST_RUN)) begin
            w_phase_next = 1'b0;
        end else if (btn_inc) begin
            w_phase_next = 1'b0;
        end else if (blink_tick) begin
            w_phase_next = ~r_phase;
        end else begin
            w_phase_next = r_phase;
        end
    end

    // Control state and registered display-control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= ST_RUN;
            r_phase     <= 1'b0;
            r_day_night <= 1'b0;
            r_blank_h   <= 1'b0;
            r_blank_m   <= 1'b0;
            r_chime     <= 1'b0;
        end else begin
            r_mode      <= w_mode_next;
            r_phase     <= w_phase_next;
            r_day_night <= r_day_night ^ btn_fmt;
            r_blank_h   <= (w_mode_next == ST_SET_H) & w_phase_next;
            r_blank_m   <= (w_mode_next == ST_SET_M) & w_phase_next;
            r_chime     <= CHIME_EN & w_chime_evt;
        end
    end

    assign mode      = r_mode;
    assign day_night = r_day_night;
    assign blank_h   = r_blank_h;
    assign blank_m   = r_blank_m;
    assign chime     = r_chime;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: stimulus pushes hand-computed
// expectations, a monitor pops and compares one cycle later.
module tb_clock_time_ctrl;

    localparam logic [4:0] V_0 = 5'b00000;
    localparam logic [4:0] V_S = 5'b10000;
    localparam logic [4:0] V_B = 5'b01000;
    localparam logic [4:0] V_M = 5'b00100;
    localparam logic [4:0] V_I = 5'b00010;
    localparam logic [4:0] V_F = 5'b00001;

`ifdef HOURLY_CHIME_EN
    localparam logic CH_EXP = 1'b1;
`else
    localparam logic CH_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, blink_tick, btn_mode, btn_inc, btn_fmt;
    logic [3:0] bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su;
    logic       day_night, blank_h, blank_m, chime;
    logic [1:0] mode;

    typedef struct {
        logic [29:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [29:0] got_v;
    assign got_v = {bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su,
                    mode, day_night, blank_h, blank_m, chime};

    clock_time_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .blink_tick (blink_tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_fmt    (btn_fmt),
        .bcd_ht     (bcd_ht),
        .bcd_hu     (bcd_hu),
        .bcd_mt     (bcd_mt),
        .bcd_mu     (bcd_mu),
        .bcd_st     (bcd_st),
        .bcd_su     (bcd_su),
        .day_night  (day_night),
        .mode       (mode),
        .blank_h    (blank_h),
        .blank_m    (blank_m),
        .chime      (chime)
    );

    always #5 clk = ~clk;

    task automatic compare(input logic [29:0] got, input logic [29:0] expv, input string nm);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h (HHMMSS=%h mode=%0d dn=%b bh=%b bm=%b ch=%b) expected %h",
                     nm, got, got[29:6], got[5:4], got[3], got[2], got[1], got[0], expv);
        end
    endtask

    // Drive one cycle of input pulses; optionally queue the expected outputs.
    task automatic go(input logic [4:0] in_v, input bit chk, input logic [23:0] t,
                      input logic [1:0] md, input logic dn, input logic bh,
                      input logic bm, input logic ch, input string nm);
        exp_t e;
        @(negedge clk);
        {sec_tick, blink_tick, btn_mode, btn_inc, btn_fmt} = in_v;
        if (chk) begin
            e.v  = {t, md, dn, bh, bm, ch};
            e.nm = nm;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        {sec_tick, blink_tick, btn_mode, btn_inc, btn_fmt} = V_0;
    endtask

    task automatic rep(input logic [4:0] in_v, input int n);
        for (int k = 0; k < n; k++) go(in_v, 1'b0, 24'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "");
    endtask

    // Monitor: outputs are registered, so they are checked just after the edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            compare(got_v, mon_e.v, mon_e.nm);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {sec_tick, blink_tick, btn_mode, btn_inc, btn_fmt} = V_0;
        repeat (3) @(negedge clk);
        compare(got_v, 30'h0, "reset_init");
        rst = 1'b0;

        // Run a few seconds; btn_inc in RUN does nothing.
        go(V_S, 1, 24'h000001, 2'd0, 0, 0, 0, 0, "run_s1");
        go(V_S, 1, 24'h000002, 2'd0, 0, 0, 0, 0, "run_s2");
        go(V_S, 1, 24'h000003, 2'd0, 0, 0, 0, 0, "run_s3");
        go(V_I, 1, 24'h000003, 2'd0, 0, 0, 0, 0, "inc_in_run");

        // Hour setting with wrap 23 -> 00.
        go(V_M, 1, 24'h000003, 2'd1, 0, 0, 0, 0, "enter_set_h");
        rep(V_I, 22);
        go(V_I, 1, 24'h230003, 2'd1, 0, 0, 0, 0, "hour_23");
        go(V_I, 1, 24'h000003, 2'd1, 0, 0, 0, 0, "hour_wrap");
        go(V_I, 1, 24'h010003, 2'd1, 0, 0, 0, 0, "hour_01");

        // Freeze and blink in SET_H.
        rep(V_S, 4);
        go(V_S, 1, 24'h010003, 2'd1, 0, 0, 0, 0, "freeze_set_h");
        go(V_B, 1, 24'h010003, 2'd1, 0, 1, 0, 0, "blink1");
        go(V_B, 1, 24'h010003, 2'd1, 0, 0, 0, 0, "blink2");
        go(V_B, 1, 24'h010003, 2'd1, 0, 1, 0, 0, "blink3");
        go(V_I, 1, 24'h020003, 2'd1, 0, 0, 0, 0, "inc_unblanks");

        // Mode beats increment; then minute setting with wrap, no carry.
        go(V_M | V_I, 1, 24'h020003, 2'd2, 0, 0, 0, 0, "mode_beats_inc");
        rep(V_I, 58);
        go(V_I, 1, 24'h025903, 2'd2, 0, 0, 0, 0, "min_59");
        go(V_I, 1, 24'h020003, 2'd2, 0, 0, 0, 0, "min_wrap_nochime");
        go(V_I, 1, 24'h020103, 2'd2, 0, 0, 0, 0, "min_01");
        go(V_B, 1, 24'h020103, 2'd2, 0, 0, 1, 0, "blink_m");
        go(V_M, 1, 24'h020100, 2'd0, 0, 0, 0, 0, "exit_clears_sec");

        // Format toggles in every mode; hours stay in 24 h form.
        go(V_F, 1, 24'h020100, 2'd0, 1, 0, 0, 0, "fmt_run");
        go(V_M, 1, 24'h020100, 2'd1, 1, 0, 0, 0, "to_set_h");
        rep(V_I, 12);
        go(V_I, 1, 24'h150100, 2'd1, 1, 0, 0, 0, "hour_15");
        go(V_F, 1, 24'h150100, 2'd1, 0, 0, 0, 0, "fmt_set_h");
        rep(V_I, 7);
        go(V_I, 1, 24'h230100, 2'd1, 0, 0, 0, 0, "preset_23");
        go(V_M, 1, 24'h230100, 2'd2, 0, 0, 0, 0, "to_set_m");
        go(V_F, 1, 24'h230100, 2'd2, 1, 0, 0, 0, "fmt_set_m");
        rep(V_I, 57);
        go(V_I, 1, 24'h235900, 2'd2, 1, 0, 0, 0, "preset_59");
        go(V_M, 1, 24'h235900, 2'd0, 1, 0, 0, 0, "back_to_run");

        // Midnight rollover in a single tick.
        rep(V_S, 58);
        go(V_S, 1, 24'h235959, 2'd0, 1, 0, 0, 0, "t_235959");
        go(V_S, 1, 24'h000000, 2'd0, 1, 0, 0, CH_EXP, "midnight");
        go(V_0, 1, 24'h000000, 2'd0, 1, 0, 0, 0, "chime_one_cycle");

        // sec_tick together with btn_mode in RUN.
        rep(V_S, 8);
        go(V_S, 1, 24'h000009, 2'd0, 1, 0, 0, 0, "t_000009");
        go(V_S | V_M, 1, 24'h000010, 2'd1, 1, 0, 0, 0, "tick_and_mode");
        go(V_B, 1, 24'h000010, 2'd1, 1, 1, 0, 0, "blink_before_rst");

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare(got_v, 30'h0, "async_reset");
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
